// File: rtl/sprite_renderer.sv
// Sprite address generator and compositor feeding the sprite ROM.
// Optional colour-keyed transparency: define SPRITE_TRANSPARENT_EN.
module sprite_renderer #(
  parameter int          SPR_W      = 20,
  parameter int          SPR_H      = 20,
  parameter int          FRAMES     = 1,
  parameter int          ANIM_DIV   = 8,
  parameter int          ADDR_WIDTH = 20,
  parameter logic [11:0] KEY_RGB    = 12'h0F0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  pixel_valid,
  input  logic [9:0]            pixel_x,
  input  logic [9:0]            pixel_y,
  input  logic [11:0]           bg_rgb,
  input  logic                  pos_wr,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [11:0]           rom_data,
  output logic [11:0]           rgb_o,
  output logic                  rgb_valid
);

  localparam int AN_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int IMG  = SPR_W * SPR_H;

  localparam logic [AN_W-1:0] ANIM_LAST = AN_W'(FRAMES - 1);
  localparam logic [DV_W-1:0] DIV_LAST  = DV_W'(ANIM_DIV - 1);

  logic [9:0]      pend_x;
  logic [9:0]      pend_y;
  logic [9:0]      act_x;
  logic [9:0]      act_y;
  logic [AN_W-1:0] anim;
  logic [DV_W-1:0] div;

  logic [10:0]           px;
  logic [10:0]           py;
  logic [10:0]           ax;
  logic [10:0]           ay;
  logic [10:0]           dx;
  logic [10:0]           dy;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] addr_next;

  logic        hit_d1;
  logic        valid_d1;
  logic [11:0] bg_d1;
  logic        hit_d2;
  logic        valid_d2;
  logic [11:0] bg_d2;

  logic        use_rom;
  logic [11:0] rgb_next;

  // Position double buffer and animation stepping
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_x <= '0;
      pend_y <= '0;
      act_x  <= '0;
      act_y  <= '0;
      anim   <= '0;
      div    <= '0;
    end else begin
      if (pos_wr) begin
        pend_x <= pos_x;
        pend_y <= pos_y;
      end
      if (frame_start) begin
        act_x <= pend_x;
        act_y <= pend_y;
        if (div == DIV_LAST) begin
          div <= '0;
          if (anim == ANIM_LAST)
            anim <= '0;
          else
            anim <= anim + 1'b1;
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

  // 11-bit compares so a sprite near the right/bottom edge clips
  always_comb begin
    px  = {1'b0, pixel_x};
    py  = {1'b0, pixel_y};
    ax  = {1'b0, act_x};
    ay  = {1'b0, act_y};
    dx  = px - ax;
    dy  = py - ay;
    hit = pixel_valid
        && (px >= ax) && (px < ax + 11'(SPR_W))
        && (py >= ay) && (py < ay + 11'(SPR_H));
    addr_next = '0;
    if (hit)
      addr_next = ADDR_WIDTH'(anim) * ADDR_WIDTH'(IMG)
                + ADDR_WIDTH'(dy) * ADDR_WIDTH'(SPR_W)
                + ADDR_WIDTH'(dx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr <= '0;
      hit_d1   <= 1'b0;
      valid_d1 <= 1'b0;
      bg_d1    <= '0;
    end else begin
      rom_addr <= addr_next;
      hit_d1   <= hit;
      valid_d1 <= pixel_valid;
      bg_d1    <= bg_rgb;
    end
  end

  // Aligns with rom_data, which the ROM registers on this same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_d2   <= 1'b0;
      valid_d2 <= 1'b0;
      bg_d2    <= '0;
    end else begin
      hit_d2   <= hit_d1;
      valid_d2 <= valid_d1;
      bg_d2    <= bg_d1;
    end
  end

  always_comb begin
`ifdef SPRITE_TRANSPARENT_EN
    use_rom = hit_d2 && (rom_data != KEY_RGB);
`else
    use_rom = hit_d2;
`endif
    rgb_next = '0;
    if (valid_d2)
      rgb_next = use_rom ? rom_data : bg_d2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_o     <= '0;
      rgb_valid <= 1'b0;
    end else begin
      rgb_o     <= rgb_next;
      rgb_valid <= valid_d2;
    end
  end

endmodule

// File: tb/tb_sprite_renderer.sv
// Randomized bench for sprite_renderer against a frame-level model.
// Honours SPRITE_TRANSPARENT_EN in the model as well.
module tb_sprite_renderer;

  localparam int SW  = 20;
  localparam int SH  = 20;
  localparam int FR  = 3;
  localparam int AD  = 2;
  localparam int AWD = 20;
  localparam int KEY = 'h0F0;
  localparam int NC  = 8192;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_start;
  logic           pixel_valid;
  logic [9:0]     pixel_x;
  logic [9:0]     pixel_y;
  logic [11:0]    bg_rgb;
  logic           pos_wr;
  logic [9:0]     pos_x;
  logic [9:0]     pos_y;
  logic [AWD-1:0] rom_addr;
  logic [11:0]    rom_data;
  logic [11:0]    rgb_o;
  logic           rgb_valid;

  sprite_renderer #(
    .SPR_W(SW), .SPR_H(SH), .FRAMES(FR), .ANIM_DIV(AD),
    .ADDR_WIDTH(AWD), .KEY_RGB(12'h0F0)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .bg_rgb(bg_rgb), .pos_wr(pos_wr), .pos_x(pos_x), .pos_y(pos_y),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .rgb_o(rgb_o), .rgb_valid(rgb_valid)
  );

  always #5 clk = ~clk;

  // ROM contents: each word holds its own address
  always @(posedge clk) rom_data <= rom_addr[11:0];

  int total = 0;
  int bad   = 0;

  int pend_x, pend_y, act_x, act_y, nfr;
  int e_addr [NC];
  int e_rgb  [NC];
  int e_val  [NC];
  int cyc_n   = 0;
  bit started = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  task automatic cyc(input bit rst, input bit fs, input bit pw,
                     input int nx, input int ny, input bit v,
                     input int x, input int y, input int bg);
    int anim, addr, rgb, rd;
    bit hit;
    @(negedge clk);
    if (started) begin
      chk("rom_addr", 32'(rom_addr), e_addr[cyc_n-1]);
      chk("rgb_o", 32'(rgb_o), cyc_n >= 3 ? e_rgb[cyc_n-3] : 0);
      chk("rgb_valid", 32'(rgb_valid), cyc_n >= 3 ? e_val[cyc_n-3] : 0);
    end
    reset       = rst;
    frame_start = fs;
    pos_wr      = pw;
    pos_x       = 10'(nx);
    pos_y       = 10'(ny);
    pixel_valid = v;
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    bg_rgb      = 12'(bg);
    anim = (nfr / AD) % FR;
    hit  = v && x >= act_x && x < act_x + SW && y >= act_y && y < act_y + SH;
    addr = hit ? (anim * SW * SH + (y - act_y) * SW + (x - act_x)) % (1 << AWD) : 0;
    rd   = addr % 4096;
    rgb  = !v ? 0 : (hit ? rd : bg);
`ifdef SPRITE_TRANSPARENT_EN
    if (v && hit && rd == KEY) rgb = bg;
`endif
    e_addr[cyc_n] = addr;
    e_rgb[cyc_n]  = rgb;
    e_val[cyc_n]  = int'(v);
    if (rst) begin
      for (int k = 0; k < 3; k++)
        if (cyc_n - k >= 0) begin
          e_addr[cyc_n-k] = (k == 0) ? 0 : e_addr[cyc_n-k];
          e_rgb[cyc_n-k]  = 0;
          e_val[cyc_n-k]  = 0;
        end
      pend_x = 0; pend_y = 0; act_x = 0; act_y = 0; nfr = 0;
      started = 1;
    end else begin
      if (fs) begin
        act_x = pend_x; act_y = pend_y; nfr++;
      end
      if (pw) begin
        pend_x = nx; pend_y = ny;
      end
    end
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic setpos(input int nx, input int ny);
    cyc(0, 0, 1, nx, ny, 0, 0, 0, 0);
  endtask

  task automatic frame();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic scan(input int y, input int x0, input int x1, input int bg);
    for (int x = x0; x <= x1; x++) cyc(0, 0, 0, 0, 0, 1, x, y, bg);
  endtask

  initial begin
    int r, x, y;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(6);
    // basic row through sprite at (100,50)
    setpos(100, 50);
    frame();
    scan(50, 98, 121, 'h00F);
    scan(69, 98, 121, 'h123);
    scan(70, 98, 121, 'h456);
    // pending write mid-frame must not move the sprite
    setpos(200, 60);
    scan(50, 98, 121, 'h00F);
    cyc(0, 1, 1, 300, 70, 0, 0, 0, 0);
    scan(60, 198, 221, 'h0AA);
    scan(70, 298, 321, 'h0BB);
    frame();
    scan(70, 298, 321, 'h0CC);
    scan(60, 198, 221, 'h0DD);
    // bottom-right clipping, no wrap
    setpos(630, 470);
    frame();
    scan(469, 625, 639, 'h111);
    scan(470, 625, 639, 'h222);
    scan(479, 620, 639, 'h333);
    scan(0, 0, 21, 'h444);
    scan(470, 0, 21, 'h555);
    // animation base stepping
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    setpos(100, 50);
    frame();
    for (int f = 0; f < 8; f++) begin
      scan(50, 100, 102, 'h777);
      frame();
    end
    // colour-key pixel (ROM word 0x0F0), then reset mid-line
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    setpos(100, 50);
    frame();
    scan(62, 99, 101, 'hABC);
    scan(51, 100, 104, 'h0EE);
    cyc(1, 0, 0, 0, 0, 1, 105, 51, 'h0EE);
    scan(51, 106, 112, 'h0EE);
    scan(0, 0, 4, 'h0FF);
    // randomized traffic around the active sprite
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 199));
      x = act_x - 5 + int'($urandom_range(0, 29));
      y = act_y - 5 + int'($urandom_range(0, 29));
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      if (r == 0) begin
        cyc(1, 0, 0, 0, 0, 1, x, y, int'($urandom_range(0, 4095)));
      end else begin
        cyc(0, r < 6, $urandom_range(0, 19) == 0,
            int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
            $urandom_range(0, 4) != 0, x, y, int'($urandom_range(0, 4095)));
      end
    end
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Pixel-pipeline stage that sits directly upstream of the character sprite ROM: it turns the VGA pixel coordinate stream into ROM read addresses, re-aligns the ROM's one-cycle registered read data with its pixel, and composites sprite over background into the final 12-bit RGB444 pixel. It also owns the sprite's on-screen position (double-buffered, committed at frame start) and a frame-based animation counter that selects among stacked sprite images in the ROM.

## Interface
- SPR_W, 20: sprite width in pixels
- SPR_H, 20: sprite height in pixels
- FRAMES, 1: number of animation images stacked in ROM (image k at base k*SPR_W*SPR_H)
- ANIM_DIV, 8: video frames per animation step (≥1)
- ADDR_WIDTH, 20: ROM address width
- KEY_RGB, 12'h0F0: transparent colour key
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of each video frame
- pixel_valid  in  1  active-video qualifier for pixel_x/pixel_y
- pixel_x  in  10  current pixel column
- pixel_y  in  10  current pixel row
- bg_rgb  in  12  background colour for current pixel
- pos_wr  in  1  write pending sprite position
- pos_x  in  10  new sprite left edge
- pos_y  in  10  new sprite top edge
- rom_addr  out  ADDR_WIDTH  address to sprite ROM (registered)
- rom_data  in  12  ROM read data, valid one cycle after rom_addr
- rgb_o  out  12  composited pixel
- rgb_valid  out  1  rgb_o qualifier (pixel_valid delayed)

## Operation
- Position: pos_wr loads pend_x/pend_y; active act_x/act_y take pend values on frame_start only. pos_wr and frame_start same cycle: new pend value is written, active takes the old pend value (new one commits next frame).
- Hit test (11-bit unsigned, no wrap): hit = pixel_valid && pixel_x ≥ act_x && pixel_x < act_x+SPR_W && pixel_y ≥ act_y && pixel_y < act_y+SPR_H. Sprite partially past 639/479 clips; never wraps to column 0.
- Address: anim*SPR_W*SPR_H + (pixel_y-act_y)*SPR_W + (pixel_x-act_x), truncated to ADDR_WIDTH. When !hit, rom_addr holds 0.
- Animation: div counter increments on frame_start; at ANIM_DIV-1 it clears and anim increments, wrapping FRAMES-1 → 0. FRAMES=1: anim fixed 0.
- Composite: rgb_o = hit_d2 ? rom_data : bg_d2 (subject to Configuration). rgb_o = 12'h000 when valid_d2 is 0.
- Reset: rom_addr=0, rgb_o=0, rgb_valid=0, pend/act position=0, anim=0, div=0, all pipeline qualifiers cleared. Reset mid-line: outputs are 0 from the following edge until fresh pixels traverse the pipeline; no stale hit emerges.

## Timing
- Stage 1 (edge t+1): rom_addr, hit_d1, bg_d1, valid_d1 registered from inputs at cycle t.
- Stage 2 (edge t+2): ROM registers rom_data; hit_d2, bg_d2, valid_d2 registered.
- Stage 3 (edge t+3): rgb_o, rgb_valid registered. Total latency 3 clocks, throughput 1 pixel/clock, no stalls.
- Position/animation changes take effect for pixels presented at or after the cycle following frame_start.

## Configuration
- SPRITE_TRANSPARENT_EN defined: a hit pixel whose rom_data == KEY_RGB outputs bg_d2 instead (colour-keyed transparency).
- Undefined: every hit pixel outputs rom_data, including KEY_RGB values.

## Test plan
- Reset held 2 cycles then released with idle inputs -> rom_addr=0, rgb_o=0, rgb_valid=0 on every cycle.
- pos_wr (100,50), frame_start, then scan row 50 cols 98..121, bg=12'h00F, ROM model returns addr as data -> rgb_o at t+3: 12'h00F for cols 98,99,120,121; addr 0..19 for cols 100..119.
- pos_wr during frame with sprite at (100,50) -> rendering unchanged until next frame_start; pos_wr coincident with frame_start -> commits one frame later.
- Sprite at (630,470) -> cols 630..639 rows 470..479 hit, column 0 and row 0 never hit.
- FRAMES=3, ANIM_DIV=2, 8 frame_starts -> base address sequence 0,0,400,400,800,800,0,0.
- With SPRITE_TRANSPARENT_EN, ROM returns 12'h0F0 at a hit pixel, bg=12'hABC -> rgb_o=12'hABC; without macro -> rgb_o=12'h0F0.
